myproject: RTL and testbench
============================

Name: myproject

Overview:
- Streaming image-feature head at the end of the frame-processing chain. Consumes one cropped single-channel 48x48 frame of signed 16-bit fixed-point pixels (15 integer bits + sign, 0 fractional) over an AXI-Stream-style input.
- Produces five 16-bit features, each on its own output stream: four saturated quadrant sums and the frame maximum.
- Controlled by an ap_ctrl_hs block-level handshake.

Parameters:
- FP_TOTAL, 16, pixel and feature width in bits (two's complement, integer format).
- IMG_ROWS, 48, frame rows; must be even.
- IMG_COLS, 48, frame columns; must be even.
- ACC_W, 32, quadrant accumulator width; must hold IMG_ROWS*IMG_COLS/4 * 2^(FP_TOTAL-1) without overflow.

Ports:
- ap_clk  input  1  single clock; all logic on rising edge.
- ap_rst_n  input  1  synchronous, active-low reset.
- ap_start  input  1  start request, sampled only in IDLE; a 1-cycle pulse suffices.
- ap_idle  output  1  high while in IDLE.
- ap_ready  output  1  1-cycle pulse when the last input pixel is accepted.
- ap_done  output  1  1-cycle pulse when all five features have been accepted.
- conv2d_input_V_data_0_V_TDATA  input  FP_TOTAL  pixel, raster order, row-major.
- conv2d_input_V_data_0_V_TVALID  input  1  pixel valid.
- conv2d_input_V_data_0_V_TREADY  output  1  block accepts pixel.
- layer15_out_V_data_k_V_TDATA (k=0..4)  output  FP_TOTAL each  feature k.
- layer15_out_V_data_k_V_TVALID (k=0..4)  output  1 each  feature k valid.
- layer15_out_V_data_k_V_TREADY (k=0..4)  input  1 each  sink ready for feature k.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge, including mid-frame): the block enters IDLE and clears the row/col counters, accumulators, max register, ap_ready, ap_done, all TREADY/TVALID and all TDATA to 0. ap_idle=1.
- IDLE: if ap_start=1, clear the accumulators and counters, set max to -2^(FP_TOTAL-1), and move to READ.
- READ: input TREADY=1.
  - A pixel is accepted when TVALID&TREADY at a clock edge; accepted pixels are sign-extended.
  - Quadrant = {row>=IMG_ROWS/2, col>=IMG_COLS/2}: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right. The pixel is added to that quadrant's ACC_W accumulator.
  - Max is updated with a signed compare.
  - Col wraps at IMG_COLS-1, then row increments.
  - On acceptance of pixel (IMG_ROWS-1, IMG_COLS-1): ap_ready pulses in the next cycle, TREADY drops in the next cycle, and the state moves to WRITE.
  - TVALID without TREADY (outside READ) is ignored; no pixel is lost or double-counted.
- WRITE:
  - On the first WRITE cycle, all five TVALIDs assert together.
  - TDATA k (k=0..3) = quadrant sum k saturated to [-2^(FP_TOTAL-1), 2^(FP_TOTAL-1)-1]. TDATA 4 = max.
  - Each channel holds TVALID and TDATA stable until its own TVALID&TREADY, then drops TVALID. Channels complete independently and in any order.
  - After the last channel completes, move to DONE.
- DONE: ap_done=1 for exactly one cycle, then return to IDLE.
- ap_start in any state other than IDLE is ignored.
- Latency: frame start to ap_ready is at least IMG_ROWS*IMG_COLS cycles. Best case, ap_done is 2 cycles after the last pixel.
- No combinational path from any input to any output; all handshake outputs are registered.
- Back-to-back frames: each frame needs a new ap_start after IDLE is re-entered. Accumulators restart from 0.

Test Plan:
- All pixels = 1, always-valid/always-ready -> outputs 0..3 = 576, output 4 = 1; ap_ready pulses once; ap_done pulses once; then ap_idle=1.
- Quadrant constants TL=1, TR=2, BL=-3, BR=100 -> outputs 576, 1152, -1728, 32767 (saturated from 57600), max 100.
- All pixels = 0x8000 (-32768) -> outputs 0..3 = -32768 (negative saturation), output 4 = -32768.
- Random input TVALID and random per-channel output TREADY (50%), ramp frame pixel=(row*48+col) mod 256 -> results identical to the no-stall run; each feature is transferred exactly once, and TDATA stays stable while stalled.
- Reset asserted after 1000 pixels, then a fresh start with all-ones frame -> outputs 576 x4 and 1; no residue from the aborted frame.
- ap_start pulsed during READ/WRITE -> ignored; a second frame started after ap_done gives correct independent results.

Source files
------------

// File: rtl/myproject.sv
// Streaming feature head: four saturated quadrant sums plus the frame maximum
// of one signed pixel frame, with an ap_ctrl_hs block-level handshake.
module myproject #(
    parameter int FP_TOTAL = 16,
    parameter int IMG_ROWS = 48,
    parameter int IMG_COLS = 48,
    parameter int ACC_W    = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic [FP_TOTAL-1:0] conv2d_input_V_data_0_V_TDATA,
    input  logic                conv2d_input_V_data_0_V_TVALID,
    output logic                conv2d_input_V_data_0_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_0_V_TDATA,
    output logic                layer15_out_V_data_0_V_TVALID,
    input  logic                layer15_out_V_data_0_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_1_V_TDATA,
    output logic                layer15_out_V_data_1_V_TVALID,
    input  logic                layer15_out_V_data_1_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_2_V_TDATA,
    output logic                layer15_out_V_data_2_V_TVALID,
    input  logic                layer15_out_V_data_2_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_3_V_TDATA,
    output logic                layer15_out_V_data_3_V_TVALID,
    input  logic                layer15_out_V_data_3_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_4_V_TDATA,
    output logic                layer15_out_V_data_4_V_TVALID,
    input  logic                layer15_out_V_data_4_V_TREADY
);

    localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] HALF_ROW = ROW_W'(IMG_ROWS / 2);
    localparam logic [COL_W-1:0] HALF_COL = COL_W'(IMG_COLS / 2);

    localparam logic [FP_TOTAL-1:0]     FP_MAX = {1'b0, {(FP_TOTAL-1){1'b1}}};
    localparam logic [FP_TOTAL-1:0]     FP_MIN = {1'b1, {(FP_TOTAL-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(FP_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ROW_W-1:0]          r_row;
    logic [COL_W-1:0]          r_col;
    logic signed [ACC_W-1:0]   r_acc [4];
    logic [FP_TOTAL-1:0]       r_max;
    logic                      r_in_tready;
    logic                      r_ap_idle;
    logic                      r_ap_ready;
    logic                      r_ap_done;
    logic [4:0]                r_out_valid;
    logic [FP_TOTAL-1:0]       r_out_data [5];

    logic                      w_pix_fire;
    logic                      w_last_pix;
    logic [1:0]                w_quad;
    logic signed [ACC_W-1:0]   w_pix_ext;
    logic signed [ACC_W-1:0]   w_acc_next [4];
    logic [FP_TOTAL-1:0]       w_max_next;
    logic [4:0]                w_out_tready;
    logic [4:0]                w_valid_rem;

    function automatic logic [FP_TOTAL-1:0] f_sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_HI) begin
            return FP_MAX;
        end else if (a < SAT_LO) begin
            return FP_MIN;
        end
        return a[FP_TOTAL-1:0];
    endfunction

    assign w_out_tready = {layer15_out_V_data_4_V_TREADY, layer15_out_V_data_3_V_TREADY,
                           layer15_out_V_data_2_V_TREADY, layer15_out_V_data_1_V_TREADY,
                           layer15_out_V_data_0_V_TREADY};

    // TREADY is only ever high in READ, so a fire never happens in other states.
    assign w_pix_fire  = r_in_tready & conv2d_input_V_data_0_V_TVALID;
    assign w_last_pix  = w_pix_fire && (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_quad      = {r_row >= HALF_ROW, r_col >= HALF_COL};
    assign w_pix_ext   = {{(ACC_W-FP_TOTAL){conv2d_input_V_data_0_V_TDATA[FP_TOTAL-1]}},
                          conv2d_input_V_data_0_V_TDATA};
    assign w_max_next  = (w_pix_fire &&
                          ($signed(conv2d_input_V_data_0_V_TDATA) > $signed(r_max)))
                         ? conv2d_input_V_data_0_V_TDATA : r_max;
    assign w_valid_rem = r_out_valid & ~w_out_tready;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            w_acc_next[q] = r_acc[q];
            if (w_pix_fire && (w_quad == 2'(q))) begin
                w_acc_next[q] = r_acc[q] + w_pix_ext;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_state_next = S_READ;
            S_READ:  if (w_last_pix) w_state_next = S_WRITE;
            S_WRITE: if (w_valid_rem == 5'b0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the accumulator array is small register state, not RAM, so it is cleared by reset like everything else.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_max       <= '0;
            r_in_tready <= 1'b0;
            r_ap_idle   <= 1'b1;
            r_ap_ready  <= 1'b0;
            r_ap_done   <= 1'b0;
            r_out_valid <= '0;
            for (int q = 0; q < 4; q++) r_acc[q] <= '0;
            for (int k = 0; k < 5; k++) r_out_data[k] <= '0;
        end else begin
            r_ap_idle  <= (w_state_next == S_IDLE);
            r_ap_ready <= w_last_pix;
            r_ap_done  <= (r_state == S_WRITE) && (w_state_next == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_row       <= '0;
                        r_col       <= '0;
                        r_max       <= FP_MIN;
                        r_in_tready <= 1'b1;
                        for (int q = 0; q < 4; q++) r_acc[q] <= '0;
                    end
                end
                S_READ: begin
                    if (w_pix_fire) begin
                        r_max <= w_max_next;
                        for (int q = 0; q < 4; q++) r_acc[q] <= w_acc_next[q];
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    // Results are loaded from the post-update values so WRITE starts on the next cycle.
                    if (w_last_pix) begin
                        r_in_tready <= 1'b0;
                        r_out_valid <= '1;
                        for (int q = 0; q < 4; q++) r_out_data[q] <= f_sat(w_acc_next[q]);
                        r_out_data[4] <= w_max_next;
                    end
                end
                S_WRITE: begin
                    r_out_valid <= w_valid_rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign ap_idle  = r_ap_idle;
    assign ap_ready = r_ap_ready;
    assign ap_done  = r_ap_done;
    assign conv2d_input_V_data_0_V_TREADY = r_in_tready;

    assign layer15_out_V_data_0_V_TDATA  = r_out_data[0];
    assign layer15_out_V_data_1_V_TDATA  = r_out_data[1];
    assign layer15_out_V_data_2_V_TDATA  = r_out_data[2];
    assign layer15_out_V_data_3_V_TDATA  = r_out_data[3];
    assign layer15_out_V_data_4_V_TDATA  = r_out_data[4];
    assign layer15_out_V_data_0_V_TVALID = r_out_valid[0];
    assign layer15_out_V_data_1_V_TVALID = r_out_valid[1];
    assign layer15_out_V_data_2_V_TVALID = r_out_valid[2];
    assign layer15_out_V_data_3_V_TVALID = r_out_valid[3];
    assign layer15_out_V_data_4_V_TVALID = r_out_valid[4];

endmodule

// File: tb/tb_myproject.sv
// Directed bench for myproject: known frames, stalls on both sides, mid-frame
// reset and ignored start pulses, each scenario checking its own results.
module tb_myproject;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [15:0] in_tdata  = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [15:0] out_tdata [5];
    logic [4:0]  out_tvalid;
    logic [4:0]  out_tready = '0;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] got [5];
    int          got_cnt [5];
    int          n_rdy, n_done, rdy_cyc, done_cyc, last_acc_cyc;
    bit          stable_ok, tmo;

    always #5 ap_clk = ~ap_clk;

    myproject dut (
        .ap_clk                         (ap_clk),
        .ap_rst_n                       (ap_rst_n),
        .ap_start                       (ap_start),
        .ap_idle                        (ap_idle),
        .ap_ready                       (ap_ready),
        .ap_done                        (ap_done),
        .conv2d_input_V_data_0_V_TDATA  (in_tdata),
        .conv2d_input_V_data_0_V_TVALID (in_tvalid),
        .conv2d_input_V_data_0_V_TREADY (in_tready),
        .layer15_out_V_data_0_V_TDATA   (out_tdata[0]),
        .layer15_out_V_data_0_V_TVALID  (out_tvalid[0]),
        .layer15_out_V_data_0_V_TREADY  (out_tready[0]),
        .layer15_out_V_data_1_V_TDATA   (out_tdata[1]),
        .layer15_out_V_data_1_V_TVALID  (out_tvalid[1]),
        .layer15_out_V_data_1_V_TREADY  (out_tready[1]),
        .layer15_out_V_data_2_V_TDATA   (out_tdata[2]),
        .layer15_out_V_data_2_V_TVALID  (out_tvalid[2]),
        .layer15_out_V_data_2_V_TREADY  (out_tready[2]),
        .layer15_out_V_data_3_V_TDATA   (out_tdata[3]),
        .layer15_out_V_data_3_V_TVALID  (out_tvalid[3]),
        .layer15_out_V_data_3_V_TREADY  (out_tready[3]),
        .layer15_out_V_data_4_V_TDATA   (out_tdata[4]),
        .layer15_out_V_data_4_V_TVALID  (out_tvalid[4]),
        .layer15_out_V_data_4_V_TREADY  (out_tready[4])
    );

    // Frame patterns: 0 all ones, 1 quadrant constants, 2 all -32768, 3 ramp mod 256.
    function automatic logic [15:0] pix(input int pat, input int r, input int c);
        case (pat)
            0: return 16'd1;
            1: begin
                if (r < 24) return (c < 24) ? 16'd1 : 16'd2;
                return (c < 24) ? 16'hFFFD : 16'd100;
            end
            2: return 16'h8000;
            default: return 16'((r * 48 + c) % 256);
        endcase
    endfunction

    // Drives one frame and records what the sinks collect. Garbage pixels are
    // offered whenever the block is not expected to accept them.
    task automatic run_frame(input int pat, input bit rv, input bit rr,
                             input int stop_after, input bit start_noise);
        int          idx;
        int          cyc;
        bit          acc;
        logic [15:0] prev_d [5];
        bit          prev_pend [5];
        for (int k = 0; k < 5; k++) begin
            got[k] = 'x; got_cnt[k] = 0; prev_pend[k] = 1'b0; prev_d[k] = '0;
        end
        n_rdy = 0; n_done = 0; rdy_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
        stable_ok = 1'b1; tmo = 1'b0;
        ap_start = 1'b1; in_tvalid = 1'b1; in_tdata = 16'h7FFF; out_tready = '1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        idx = 0; cyc = 0;
        while (1) begin
            if (stop_after >= 0 && idx >= stop_after) break;
            if (ap_ready) begin n_rdy++; rdy_cyc = cyc; end
            if (ap_done)  begin n_done++; done_cyc = cyc; end
            for (int k = 0; k < 5; k++)
                if (prev_pend[k] && (!out_tvalid[k] || out_tdata[k] !== prev_d[k])) stable_ok = 1'b0;
            if (ap_done) break;
            ap_start = start_noise && ((cyc % 37 == 3) || (out_tvalid != 5'b0));
            if (idx < 2304) begin
                in_tvalid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
                in_tdata  = pix(pat, idx / 48, idx % 48);
            end else begin
                in_tvalid = 1'b1;
                in_tdata  = 16'h7FFF;
            end
            for (int k = 0; k < 5; k++) out_tready[k] = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = in_tvalid && in_tready;
            if (acc && idx < 2304) last_acc_cyc = cyc;
            for (int k = 0; k < 5; k++) begin
                if (out_tvalid[k] && out_tready[k]) begin
                    got[k] = out_tdata[k];
                    got_cnt[k]++;
                end
                prev_pend[k] = out_tvalid[k] && !out_tready[k];
                prev_d[k]    = out_tdata[k];
            end
            @(posedge ap_clk); #1;
            if (acc) idx++;
            cyc++;
            if (cyc > 20000) begin tmo = 1'b1; break; end
        end
        ap_start = 1'b0; in_tvalid = 1'b0; out_tready = '1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        n_checks++; if (ap_idle !== 1'b1)    begin n_fail++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        n_checks++; if (ap_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
        n_checks++; if (ap_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        n_checks++; if (in_tready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_tready got=%b exp=0", in_tready); end
        n_checks++; if (out_tvalid !== 5'b0) begin n_fail++; $display("FAIL reset_out_tvalid got=%b exp=00000", out_tvalid); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_tdata[k] !== 16'h0) begin n_fail++; $display("FAIL reset_tdata%0d got=%h exp=0000", k, out_tdata[k]); end
        end
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=1", ap_idle); end
    endtask

    task automatic test_all_ones();
        logic [15:0] exp [5];
        exp = '{16'd576, 16'd576, 16'd576, 16'd576, 16'd1};
        run_frame(0, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ones_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL ones_data%0d got=%h exp=%h", k, got[k], exp[k]); end
            n_checks++; if (got_cnt[k] !== 1) begin n_fail++; $display("FAIL ones_count%0d got=%0d exp=1", k, got_cnt[k]); end
        end
        n_checks++; if (n_rdy !== 1)     begin n_fail++; $display("FAIL ones_ready_pulses got=%0d exp=1", n_rdy); end
        n_checks++; if (n_done !== 1)    begin n_fail++; $display("FAIL ones_done_pulses got=%0d exp=1", n_done); end
        n_checks++; if (rdy_cyc !== 2304) begin n_fail++; $display("FAIL ones_ready_latency got=%0d exp=2304", rdy_cyc); end
        n_checks++; if (done_cyc - last_acc_cyc !== 2) begin
            n_fail++; $display("FAIL ones_done_latency got=%0d exp=2", done_cyc - last_acc_cyc);
        end
        @(posedge ap_clk); #1;
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL ones_idle_after got=%b exp=1", ap_idle); end
        n_checks++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL ones_done_width got=%b exp=0", ap_done); end
    endtask

    task automatic test_quadrants();
        logic [15:0] exp [5];
        exp = '{16'd576, 16'd1152, 16'hF940, 16'h7FFF, 16'd100};
        run_frame(1, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL quad_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL quad_data%0d got=%h exp=%h", k, got[k], exp[k]); end
            n_checks++; if (got_cnt[k] !== 1) begin n_fail++; $display("FAIL quad_count%0d got=%0d exp=1", k, got_cnt[k]); end
        end
        @(posedge ap_clk); #1;
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL quad_idle_after got=%b exp=1", ap_idle); end
    endtask

    task automatic test_neg_sat();
        run_frame(2, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL neg_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (got[k] !== 16'h8000) begin n_fail++; $display("FAIL neg_data%0d got=%h exp=8000", k, got[k]); end
            n_checks++; if (got_cnt[k] !== 1) begin n_fail++; $display("FAIL neg_count%0d got=%0d exp=1", k, got_cnt[k]); end
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_stall_ramp();
        logic [15:0] exp [5];
        exp = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h00FF};
        run_frame(3, 1'b1, 1'b1, -1, 1'b0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL ramp_data%0d got=%h exp=%h", k, got[k], exp[k]); end
            n_checks++; if (got_cnt[k] !== 1) begin n_fail++; $display("FAIL ramp_count%0d got=%0d exp=1", k, got_cnt[k]); end
        end
        n_checks++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL ramp_stall_stable got=%b exp=1", stable_ok); end
        n_checks++; if (n_rdy !== 1) begin n_fail++; $display("FAIL ramp_ready_pulses got=%0d exp=1", n_rdy); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_mid_reset();
        run_frame(1, 1'b0, 1'b0, 1000, 1'b0);
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        n_checks++; if (ap_idle !== 1'b1)   begin n_fail++; $display("FAIL midrst_idle got=%b exp=1", ap_idle); end
        n_checks++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_tready got=%b exp=0", in_tready); end
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        run_frame(0, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (got[k] !== ((k == 4) ? 16'd1 : 16'd576)) begin
                n_fail++; $display("FAIL midrst_data%0d got=%h exp=%h", k, got[k], (k == 4) ? 16'd1 : 16'd576);
            end
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [5];
        exp = '{16'd576, 16'd1152, 16'hF940, 16'h7FFF, 16'd100};
        run_frame(1, 1'b1, 1'b1, -1, 1'b1);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_a_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL b2b_a_data%0d got=%h exp=%h", k, got[k], exp[k]); end
            n_checks++; if (got_cnt[k] !== 1) begin n_fail++; $display("FAIL b2b_a_count%0d got=%0d exp=1", k, got_cnt[k]); end
        end
        n_checks++; if (n_rdy !== 1) begin n_fail++; $display("FAIL b2b_a_ready_pulses got=%0d exp=1", n_rdy); end
        @(posedge ap_clk); #1;
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_between got=%b exp=1", ap_idle); end
        run_frame(0, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_b_timeout got=%b exp=0", tmo); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (got[k] !== ((k == 4) ? 16'd1 : 16'd576)) begin
                n_fail++; $display("FAIL b2b_b_data%0d got=%h exp=%h", k, got[k], (k == 4) ? 16'd1 : 16'd576);
            end
        end
        @(posedge ap_clk); #1;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_quadrants();
        test_neg_sat();
        test_stall_ramp();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
